// File: rtl/pq_pkg.sv
// Shared post-quantum datapath types and constants.
package pq_pkg;

  typedef enum logic {
    ACC,
    DONE
  } mod_acc_state_e;

  localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

endpackage

// File: rtl/mod_acc_if.sv
// Term/result handshake bundle for mod_acc; in_sub_i exists only with MOD_ACC_SUB_EN.
interface mod_acc_if #(
  parameter int unsigned NB_BIT = 23,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [NB_BIT-1:0] in_data_i;
  logic              in_last_i;
`ifdef MOD_ACC_SUB_EN
  logic              in_sub_i;
`endif
  logic              out_valid_o;
  logic              out_ready_i;
  logic [NB_BIT-1:0] out_sum_o;
  logic [CNT_W-1:0]  out_count_o;

  modport slave (
`ifdef MOD_ACC_SUB_EN
    input  in_sub_i,
`endif
    input  in_valid_i,
    input  in_data_i,
    input  in_last_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_sum_o,
    output out_count_o
  );

  modport master (
`ifdef MOD_ACC_SUB_EN
    output in_sub_i,
`endif
    output in_valid_i,
    output in_data_i,
    output in_last_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_sum_o,
    input  out_count_o
  );
endinterface

// File: rtl/mod_add.sv
// Combinational (a + b) mod q for a, b < q, using one conditional subtract.
module mod_add #(
  parameter int unsigned NB_BIT = 23
) (
  input  logic [NB_BIT-1:0] a_i,
  input  logic [NB_BIT-1:0] b_i,
  input  logic [NB_BIT-1:0] q_i,
  output logic [NB_BIT-1:0] sum_o
);
  logic [NB_BIT:0] w_sum;
  logic [NB_BIT:0] w_q;

  assign w_sum = {1'b0, a_i} + {1'b0, b_i};
  assign w_q   = {1'b0, q_i};
  assign sum_o = (w_sum >= w_q) ? NB_BIT'(w_sum - w_q) : w_sum[NB_BIT-1:0];
endmodule

// File: rtl/mod_sub.sv
// Combinational (a - b) mod q for a, b < q; only built when MOD_ACC_SUB_EN is defined.
`ifdef MOD_ACC_SUB_EN
module mod_sub #(
  parameter int unsigned NB_BIT = 23
) (
  input  logic [NB_BIT-1:0] a_i,
  input  logic [NB_BIT-1:0] b_i,
  input  logic [NB_BIT-1:0] q_i,
  output logic [NB_BIT-1:0] diff_o
);
  logic [NB_BIT:0] w_diff;

  assign w_diff = {1'b0, a_i} - {1'b0, b_i};
  // The extra MSB is the borrow; fold back into range by adding q.
  assign diff_o = w_diff[NB_BIT] ? NB_BIT'(w_diff[NB_BIT-1:0] + q_i) : w_diff[NB_BIT-1:0];
endmodule
`endif

// File: rtl/mod_acc.sv
// Streaming modular accumulator over valid/ready bursts.
// MOD_ACC_SUB_EN adds a per-term subtract option via mod_sub.
module mod_acc
  import pq_pkg::*;
#(
  parameter int unsigned NB_BIT = 23,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB_BIT-1:0] q_i,
  mod_acc_if.slave          bus
);
  mod_acc_state_e    r_state, w_state_d;
  logic [NB_BIT-1:0] r_acc, w_acc_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_out_valid, w_out_valid_d;
  logic [NB_BIT-1:0] r_out_sum, w_out_sum_d;
  logic [CNT_W-1:0]  r_out_count, w_out_count_d;

  logic              w_accept;
  logic [NB_BIT-1:0] w_base;
  logic [CNT_W-1:0]  w_base_cnt;
  logic [NB_BIT-1:0] w_add;
  logic [NB_BIT-1:0] w_next;
  logic [CNT_W-1:0]  w_next_cnt;

  assign bus.in_ready_o = ~rst_i & ((r_state == ACC) | bus.out_ready_i);
  assign w_accept       = bus.in_valid_i & bus.in_ready_o;

  // A term taken while DONE starts a fresh burst; the accumulator is already 0 at ACC burst start.
  assign w_base     = (r_state == DONE) ? '0 : r_acc;
  assign w_base_cnt = (r_state == DONE) ? '0 : r_cnt;
  assign w_next_cnt = (w_base_cnt == '1) ? w_base_cnt : w_base_cnt + CNT_W'(1);

  mod_add #(
    .NB_BIT(NB_BIT)
  ) u_mod_add (
    .a_i  (w_base),
    .b_i  (bus.in_data_i),
    .q_i  (q_i),
    .sum_o(w_add)
  );

`ifdef MOD_ACC_SUB_EN
  logic [NB_BIT-1:0] w_sub;

  mod_sub #(
    .NB_BIT(NB_BIT)
  ) u_mod_sub (
    .a_i   (w_base),
    .b_i   (bus.in_data_i),
    .q_i   (q_i),
    .diff_o(w_sub)
  );

  assign w_next = bus.in_sub_i ? w_sub : w_add;
`else
  assign w_next = w_add;
`endif

  always_comb begin
    w_state_d     = r_state;
    w_acc_d       = r_acc;
    w_cnt_d       = r_cnt;
    w_out_valid_d = r_out_valid;
    w_out_sum_d   = r_out_sum;
    w_out_count_d = r_out_count;
    if (w_accept) begin
      if (bus.in_last_i) begin
        w_state_d     = DONE;
        w_acc_d       = '0;
        w_cnt_d       = '0;
        w_out_valid_d = 1'b1;
        w_out_sum_d   = w_next;
        w_out_count_d = w_next_cnt;
      end else begin
        w_state_d     = ACC;
        w_acc_d       = w_next;
        w_cnt_d       = w_next_cnt;
        w_out_valid_d = 1'b0;
      end
    end else if ((r_state == DONE) && bus.out_ready_i) begin
      w_state_d     = ACC;
      w_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_out_valid <= w_out_valid_d;
      r_out_sum   <= w_out_sum_d;
      r_out_count <= w_out_count_d;
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_sum_o   = r_out_sum;
  assign bus.out_count_o = r_out_count;
endmodule

// File: tb/tb_mod_acc.sv
// Directed self-checking bench for mod_acc; exercises the subtract path when MOD_ACC_SUB_EN is set.
module tb_mod_acc;
  import pq_pkg::*;

  localparam int unsigned NB_BIT = 23;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NB_BIT-1:0] q;

  int n_assert = 0;
  int n_fail   = 0;

  mod_acc_if #(.NB_BIT(NB_BIT), .CNT_W(CNT_W)) bus ();

  mod_acc #(
    .NB_BIT(NB_BIT),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .q_i  (q),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; return at the following negedge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [NB_BIT-1:0] d, input logic l);
    bus.in_valid_i = v;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] s,
                         input logic [31:0] c);
    chk({tag, "_valid"}, {31'd0, bus.out_valid_o}, {31'd0, v});
    chk({tag, "_sum"}, {9'd0, bus.out_sum_o}, s);
    chk({tag, "_count"}, {16'd0, bus.out_count_o}, c);
  endtask

  task automatic drain();
    drive(1'b0, '0, 1'b0);
    bus.out_ready_i = 1'b1;
    step();
    chk("drain_valid", {31'd0, bus.out_valid_o}, 32'd0);
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    q               = Q_DILITHIUM;
    rst             = 1'b1;
    bus.out_ready_i = 1'b1;
`ifdef MOD_ACC_SUB_EN
    bus.in_sub_i    = 1'b0;
`endif
    drive(1'b1, 23'd3, 1'b1);
    @(negedge clk);
    step();
    chk_out("reset", 1'b0, 0, 0);
    chk("reset_in_ready", {31'd0, bus.in_ready_o}, 32'd0);

    rst = 1'b0;
    drive(1'b0, '0, 1'b0);
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, bus.in_ready_o}, 32'd1);

    // {5, 7 last}
    drive(1'b1, 23'd5, 1'b0);
    step();
    chk("b1_mid_valid", {31'd0, bus.out_valid_o}, 32'd0);
    drive(1'b1, 23'd7, 1'b1);
    step();
    chk_out("b1", 1'b1, 12, 2);
    chk("b1_done_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
    drain();

    // {q-1, 1 last} wraps to 0
    drive(1'b1, 23'd8380416, 1'b0);
    step();
    drive(1'b1, 23'd1, 1'b1);
    step();
    chk_out("wrap0", 1'b1, 0, 2);
    drain();

    // {q-1, q-1 last}
    drive(1'b1, 23'd8380416, 1'b0);
    step();
    drive(1'b1, 23'd8380416, 1'b1);
    step();
    chk_out("wrapmax", 1'b1, 8380415, 2);
    drain();

    // Single term: valid appears right after the accepting edge
    drive(1'b1, 23'd42, 1'b1);
    chk("single_pre_valid", {31'd0, bus.out_valid_o}, 32'd0);
    step();
    chk_out("single", 1'b1, 42, 1);
    drain();

    // Back-to-back with the result drained immediately
    bus.out_ready_i = 1'b1;
    drive(1'b1, 23'd1, 1'b0);
    chk("b2b_rdy0", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    drive(1'b1, 23'd2, 1'b1);
    chk("b2b_rdy1", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    chk_out("b2b_first", 1'b1, 3, 2);
    drive(1'b1, 23'd3, 1'b1);
    chk("b2b_rdy2", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    chk_out("b2b_second", 1'b1, 3, 1);
    drive(1'b0, '0, 1'b0);
    step();
    chk("b2b_drained", {31'd0, bus.out_valid_o}, 32'd0);
    bus.out_ready_i = 1'b0;

    // Backpressure: result held, offered term refused
    drive(1'b1, 23'd9, 1'b1);
    step();
    drive(1'b1, 23'd4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_out("bp_hold", 1'b1, 9, 1);
      chk("bp_in_ready", {31'd0, bus.in_ready_o}, 32'd0);
      step();
    end
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_rdy", {31'd0, bus.in_ready_o}, 32'd1);
    step();
    chk_out("bp_next", 1'b1, 4, 1);
    drain();

    // Reset mid-burst discards the partial sum
    drive(1'b1, 23'd100, 1'b0);
    step();
    drive(1'b1, 23'd200, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    chk_out("midrst", 1'b0, 0, 0);
    rst = 1'b0;
    drive(1'b1, 23'd7, 1'b1);
    step();
    chk_out("after_rst", 1'b1, 7, 1);
    drain();

`ifdef MOD_ACC_SUB_EN
    // {10 add, 20 sub last} -> -10 mod q
    drive(1'b1, 23'd10, 1'b0);
    bus.in_sub_i = 1'b0;
    step();
    drive(1'b1, 23'd20, 1'b1);
    bus.in_sub_i = 1'b1;
    step();
    chk_out("sub", 1'b1, 8380407, 2);
    bus.in_sub_i = 1'b0;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
